// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle control FSM for the 16-bit datapath
// Adds memory-ready timeout, stall freeze, fault trapping and a retire counter.
module mc_control_fsm #(
   parameter int OPC_W  = 3,
   parameter int FUNC_W = 4,
   parameter int TMO_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [FUNC_W-1:0] func,
   input  logic              mem_ready,
   input  logic              stall,
   input  logic              clear_fault,
   output logic              Branch,
   output logic              IoD,
   output logic              IRWrite,
   output logic              Mem2Reg,
   output logic              MemR,
   output logic              MemW,
   output logic              PCSrc,
   output logic              PCWrite,
   output logic              RegWrite,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        BranchType,
   output logic [3:0]        ALUOp,
   output logic [3:0]        state,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic              retired,
   output logic [CNT_W-1:0]  retired_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_RTYPE    = 4'd2,
      S_RITYPE   = 4'd3,
      S_RTYPEEND = 4'd4,
      S_LW1      = 4'd5,
      S_LW2      = 4'd6,
      S_SW       = 4'd7,
      S_JALR     = 4'd8,
      S_BRANCH   = 4'd9,
      S_BRANCH2  = 4'd10,
      S_JAL      = 4'd11,
      S_LUI      = 4'd12,
      S_FAULT    = 4'd15
   } state_t;

   localparam logic [OPC_W-1:0] OP_R   = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_RI  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_RIM = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_LUI = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_JAL = OPC_W'(4);

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_cause;
   logic [1:0]         w_set_cause;
   logic [TMO_W-1:0]   r_wait;
   logic [CNT_W-1:0]   r_count;
   logic [3:0]         w_f;
   logic               w_func_hi;
   logic               w_tmo;
   logic               w_wait_state;
   logic               w_retire;

   assign w_f          = func[3:0];
   assign w_func_hi    = (func >> 4) != '0;
   assign w_tmo        = (r_wait == '1) && !mem_ready;
   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_LW1) || (r_state == S_SW);

   function automatic logic [3:0] f_alu_map(input logic [3:0] f);
      if (f <= 4'd8)
         return f;
      else if (f == 4'd9 || f == 4'd10)
         return 4'd9;
      else
         return 4'hF;
   endfunction

   always_comb begin
      w_next      = r_state;
      w_set_cause = CAUSE_NONE;
      case (r_state)
         S_FETCH: begin
            if (mem_ready) begin
               w_next = S_DECODE;
            end else if (w_tmo) begin
               w_next      = S_FAULT;
               w_set_cause = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (w_func_hi) begin
               w_next      = S_FAULT;
               w_set_cause = CAUSE_ILLEGAL;
            end else begin
               case (opcode)
                  OP_R: begin
                     if (w_f >= 4'd9) begin
                        w_next      = S_FAULT;
                        w_set_cause = CAUSE_ILLEGAL;
                     end else begin
                        w_next = S_RTYPE;
                     end
                  end
                  OP_RI: begin
                     if (w_f == 4'd11)
                        w_next = S_JALR;
                     else if (w_f >= 4'd12)
                        w_next = S_BRANCH;
                     else
                        w_next = S_RITYPE;
                  end
                  OP_RIM: begin
                     if (w_f <= 4'd10) begin
                        w_next = S_RITYPE;
                     end else begin
                        w_next      = S_FAULT;
                        w_set_cause = CAUSE_ILLEGAL;
                     end
                  end
                  OP_LUI:  w_next = S_LUI;
                  OP_JAL:  w_next = S_JAL;
                  default: begin
                     w_next      = S_FAULT;
                     w_set_cause = CAUSE_ILLEGAL;
                  end
               endcase
            end
         end
         S_RTYPE: w_next = S_RTYPEEND;
         S_RITYPE: begin
            if (w_f == 4'd9)
               w_next = S_LW1;
            else if (w_f == 4'd10)
               w_next = S_SW;
            else
               w_next = S_RTYPEEND;
         end
         S_LW1: begin
            if (mem_ready) begin
               w_next = S_LW2;
            end else if (w_tmo) begin
               w_next      = S_FAULT;
               w_set_cause = CAUSE_TIMEOUT;
            end
         end
         S_SW: begin
            if (mem_ready) begin
               w_next = S_FETCH;
            end else if (w_tmo) begin
               w_next      = S_FAULT;
               w_set_cause = CAUSE_TIMEOUT;
            end
         end
         S_BRANCH: w_next = S_BRANCH2;
         S_RTYPEEND, S_LW2, S_JAL, S_JALR, S_BRANCH2, S_LUI: w_next = S_FETCH;
         S_FAULT: begin
            if (clear_fault)
               w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      case (r_state)
         S_RTYPEEND, S_LW2, S_JAL, S_JALR, S_BRANCH2, S_LUI: w_retire = 1'b1;
         S_SW:    w_retire = mem_ready;
         default: w_retire = 1'b0;
      endcase
   end

   // FAULT ignores stall so clear_fault can always recover the machine
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_FETCH;
         r_cause <= CAUSE_NONE;
         r_wait  <= '0;
         r_count <= '0;
      end else if (r_state == S_FAULT) begin
         r_wait <= '0;
         if (clear_fault) begin
            r_state <= S_FETCH;
            r_cause <= CAUSE_NONE;
         end
      end else if (!stall) begin
         r_state <= w_next;
         if (w_next == S_FAULT)
            r_cause <= w_set_cause;
         if (w_next != r_state)
            r_wait <= '0;
         else if (w_wait_state)
            r_wait <= r_wait + TMO_W'(1);
         if (w_retire)
            r_count <= r_count + CNT_W'(1);
      end
   end

   always_comb begin
      Branch     = 1'b0;
      IoD        = 1'b0;
      IRWrite    = 1'b0;
      Mem2Reg    = 1'b0;
      MemR       = 1'b0;
      MemW       = 1'b0;
      PCSrc      = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'd0;
      ALUSrcB    = 2'd0;
      BranchType = 2'd0;
      ALUOp      = 4'hF;
      case (r_state)
         S_FETCH: begin
            MemR    = 1'b1;
            ALUOp   = 4'd0;
            ALUSrcB = 2'd1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_RTYPE: begin
            ALUOp   = f_alu_map(w_f);
            ALUSrcA = 2'd2;
            ALUSrcB = 2'd0;
         end
         S_RITYPE: begin
            ALUOp   = f_alu_map(w_f);
            ALUSrcA = 2'd2;
            ALUSrcB = 2'd2;
         end
         S_RTYPEEND: RegWrite = 1'b1;
         S_LW1: begin
            IoD  = 1'b1;
            MemR = 1'b1;
         end
         S_LW2: begin
            RegWrite = 1'b1;
            Mem2Reg  = 1'b1;
         end
         S_SW: begin
            IoD  = 1'b1;
            MemW = 1'b1;
         end
         S_JALR, S_JAL: begin
            ALUSrcA  = 2'd3;
            ALUSrcB  = 2'd1;
            ALUOp    = 4'd7;
            PCWrite  = 1'b1;
            RegWrite = (r_state == S_JALR);
         end
         S_BRANCH: begin
            ALUOp      = 4'd9;
            ALUSrcB    = 2'd2;
            Branch     = 1'b1;
            BranchType = w_f[1:0];
         end
         S_BRANCH2: begin
            ALUOp      = 4'd1;
            ALUSrcA    = 2'd2;
            Branch     = 1'b1;
            BranchType = w_f[1:0];
            PCSrc      = 1'b1;
            PCWrite    = 1'b1;
         end
         S_LUI: begin
            ALUSrcB  = 2'd3;
            ALUOp    = 4'd0;
            RegWrite = 1'b1;
         end
         default: ;
      endcase
      if (stall) begin
         RegWrite = 1'b0;
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemW     = 1'b0;
         MemR     = 1'b0;
      end
   end

   assign state         = r_state;
   assign fault         = (r_state == S_FAULT);
   assign fault_cause   = r_cause;
   assign retired       = w_retire && !stall;
   assign retired_count = r_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed bench for mc_control_fsm
// Small TMO_W/CNT_W so timeout and counter wrap are reachable quickly.
module tb_mc_control_fsm;

   localparam int OPC_W  = 3;
   localparam int FUNC_W = 4;
   localparam int TMO_W  = 2;
   localparam int CNT_W  = 3;

   logic              CLK = 1'b0;
   logic              Reset;
   logic [OPC_W-1:0]  opcode;
   logic [FUNC_W-1:0] func;
   logic              mem_ready, stall, clear_fault;
   logic              Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite, RegWrite;
   logic [1:0]        ALUSrcA, ALUSrcB, BranchType;
   logic [3:0]        ALUOp, state;
   logic              fault;
   logic [1:0]        fault_cause;
   logic              retired;
   logic [CNT_W-1:0]  retired_count;

   int checks   = 0;
   int failures = 0;

   mc_control_fsm #(.OPC_W(OPC_W), .FUNC_W(FUNC_W), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .func(func),
      .mem_ready(mem_ready), .stall(stall), .clear_fault(clear_fault),
      .Branch(Branch), .IoD(IoD), .IRWrite(IRWrite), .Mem2Reg(Mem2Reg),
      .MemR(MemR), .MemW(MemW), .PCSrc(PCSrc), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .BranchType(BranchType), .ALUOp(ALUOp),
      .state(state), .fault(fault), .fault_cause(fault_cause),
      .retired(retired), .retired_count(retired_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic fetch_decode(input logic [OPC_W-1:0] op, input logic [FUNC_W-1:0] fn);
      opcode = op;
      func   = fn;
      chk("fd_fetch", 16'(state), 16'd0);
      tick();
      chk("fd_decode", 16'(state), 16'd1);
      tick();
   endtask

   task automatic illegal(input logic [OPC_W-1:0] op, input logic [FUNC_W-1:0] fn);
      fetch_decode(op, fn);
      chk("ill_state", 16'(state), 16'd15);
      chk("ill_cause", 16'(fault_cause), 16'd1);
      clear_fault = 1'b1;
      tick();
      chk("ill_clr_state", 16'(state), 16'd0);
      chk("ill_clr_cause", 16'(fault_cause), 16'd0);
      clear_fault = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; mem_ready = 1'b1; stall = 1'b0; clear_fault = 1'b0;
      opcode = '0; func = 4'd1;
      #2;
      chk("rst_state", 16'(state), 16'd0);
      chk("rst_memr", 16'(MemR), 16'd1);
      chk("rst_alusrcb", 16'(ALUSrcB), 16'd1);
      chk("rst_aluop", 16'(ALUOp), 16'd0);
      chk("rst_irwrite", 16'(IRWrite), 16'd1);
      chk("rst_pcwrite", 16'(PCWrite), 16'd1);
      chk("rst_regwrite", 16'(RegWrite), 16'd0);
      chk("rst_fault", 16'(fault), 16'd0);
      chk("rst_cause", 16'(fault_cause), 16'd0);
      chk("rst_retired", 16'(retired), 16'd0);
      chk("rst_count", 16'(retired_count), 16'd0);
      mem_ready = 1'b0;
      #1;
      chk("rst_irwrite_lo", 16'(IRWrite), 16'd0);
      mem_ready = 1'b1;

      // R-type: opcode 0 func 1
      tick();
      Reset = 1'b1;
      #1;
      chk("r_fetch", 16'(state), 16'd0);
      tick();
      chk("r_decode", 16'(state), 16'd1);
      chk("r_decode_aluop", 16'(ALUOp), 16'hF);
      tick();
      chk("r_rtype", 16'(state), 16'd2);
      chk("r_aluop", 16'(ALUOp), 16'd1);
      chk("r_alusrca", 16'(ALUSrcA), 16'd2);
      tick();
      chk("r_end", 16'(state), 16'd4);
      chk("r_regwrite", 16'(RegWrite), 16'd1);
      chk("r_retired", 16'(retired), 16'd1);
      tick();
      chk("r_count", 16'(retired_count), 16'd1);

      // LW with three memory wait cycles in LW1, then reset mid-LW2
      opcode = 3'd2; func = 4'd9;
      tick();
      chk("lw_decode", 16'(state), 16'd1);
      tick();
      chk("lw_ritype", 16'(state), 16'd3);
      chk("lw_ritype_aluop", 16'(ALUOp), 16'd9);
      chk("lw_ritype_srcb", 16'(ALUSrcB), 16'd2);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("lw1_c1", 16'(state), 16'd5);
      chk("lw1_c1_memr", 16'(MemR), 16'd1);
      chk("lw1_c1_iod", 16'(IoD), 16'd1);
      tick();
      chk("lw1_c2", 16'(state), 16'd5);
      tick();
      chk("lw1_c3", 16'(state), 16'd5);
      chk("lw1_c3_memr", 16'(MemR), 16'd1);
      tick();
      mem_ready = 1'b1;
      #1;
      chk("lw1_c4", 16'(state), 16'd5);
      chk("lw1_c4_memr", 16'(MemR), 16'd1);
      tick();
      chk("lw2", 16'(state), 16'd6);
      chk("lw2_regwrite", 16'(RegWrite), 16'd1);
      chk("lw2_mem2reg", 16'(Mem2Reg), 16'd1);
      chk("lw2_retired", 16'(retired), 16'd1);
      chk("lw2_count", 16'(retired_count), 16'd1);
      Reset = 1'b0;
      #1;
      chk("lw2_rst_state", 16'(state), 16'd0);
      chk("lw2_rst_regwrite", 16'(RegWrite), 16'd0);
      chk("lw2_rst_count", 16'(retired_count), 16'd0);
      opcode = 3'd6; func = 4'd0;
      tick();
      Reset = 1'b1;
      #1;
      chk("post_rst_fetch", 16'(state), 16'd0);

      // illegal opcode 6, held in FAULT even under stall
      tick();
      chk("op6_decode", 16'(state), 16'd1);
      tick();
      chk("op6_fault_state", 16'(state), 16'd15);
      chk("op6_fault", 16'(fault), 16'd1);
      chk("op6_cause", 16'(fault_cause), 16'd1);
      chk("op6_aluop", 16'(ALUOp), 16'hF);
      chk("op6_memr", 16'(MemR), 16'd0);
      stall = 1'b1;
      tick();
      chk("op6_hold", 16'(state), 16'd15);
      clear_fault = 1'b1;
      tick();
      chk("op6_clr_state", 16'(state), 16'd0);
      chk("op6_clr_cause", 16'(fault_cause), 16'd0);
      chk("op6_clr_fault", 16'(fault), 16'd0);
      clear_fault = 1'b0; stall = 1'b0; mem_ready = 1'b0;
      #1;

      // timeout in FETCH after 3 held cycles
      chk("tmo_c1", 16'(state), 16'd0);
      chk("tmo_c1_irw", 16'(IRWrite), 16'd0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("tmo_hold", 16'(state), 16'd0);
         chk("tmo_irw", 16'(IRWrite), 16'd0);
      end
      tick();
      chk("tmo_fault", 16'(state), 16'd15);
      chk("tmo_cause", 16'(fault_cause), 16'd2);
      clear_fault = 1'b1;
      tick();
      chk("tmo_clr_state", 16'(state), 16'd0);
      chk("tmo_clr_cause", 16'(fault_cause), 16'd0);
      clear_fault = 1'b0; mem_ready = 1'b1;

      illegal(3'd0, 4'd9);
      illegal(3'd2, 4'd11);

      fetch_decode(3'd4, 4'd0);
      chk("jal_state", 16'(state), 16'd11);
      chk("jal_srca", 16'(ALUSrcA), 16'd3);
      chk("jal_srcb", 16'(ALUSrcB), 16'd1);
      chk("jal_aluop", 16'(ALUOp), 16'd7);
      chk("jal_pcwrite", 16'(PCWrite), 16'd1);
      chk("jal_regwrite", 16'(RegWrite), 16'd0);
      chk("jal_retired", 16'(retired), 16'd1);
      tick();
      chk("jal_count", 16'(retired_count), 16'd1);

      fetch_decode(3'd3, 4'd0);
      chk("lui_state", 16'(state), 16'd12);
      chk("lui_srcb", 16'(ALUSrcB), 16'd3);
      chk("lui_aluop", 16'(ALUOp), 16'd0);
      chk("lui_regwrite", 16'(RegWrite), 16'd1);
      tick();
      chk("lui_count", 16'(retired_count), 16'd2);

      fetch_decode(3'd1, 4'd11);
      chk("jalr_state", 16'(state), 16'd8);
      chk("jalr_regwrite", 16'(RegWrite), 16'd1);
      chk("jalr_pcwrite", 16'(PCWrite), 16'd1);
      tick();
      chk("jalr_count", 16'(retired_count), 16'd3);

      fetch_decode(3'd2, 4'd10);
      chk("sw_ritype", 16'(state), 16'd3);
      chk("sw_aluop", 16'(ALUOp), 16'd9);
      tick();
      chk("sw_state", 16'(state), 16'd7);
      chk("sw_memw", 16'(MemW), 16'd1);
      chk("sw_iod", 16'(IoD), 16'd1);
      chk("sw_retired", 16'(retired), 16'd1);
      tick();
      chk("sw_done", 16'(state), 16'd0);
      chk("sw_count", 16'(retired_count), 16'd4);

      fetch_decode(3'd1, 4'd3);
      chk("ri_state", 16'(state), 16'd3);
      chk("ri_aluop", 16'(ALUOp), 16'd3);
      chk("ri_srcb", 16'(ALUSrcB), 16'd2);
      tick();
      chk("ri_end", 16'(state), 16'd4);
      tick();
      chk("ri_count", 16'(retired_count), 16'd5);

      fetch_decode(3'd0, 4'd8);
      chk("r8_aluop", 16'(ALUOp), 16'd8);
      tick();
      tick();
      chk("r8_count", 16'(retired_count), 16'd6);

      fetch_decode(3'd2, 4'd5);
      chk("rim_aluop", 16'(ALUOp), 16'd5);
      tick();
      tick();
      chk("rim_count", 16'(retired_count), 16'd7);

      // branch with two stalled BRANCH2 cycles; retire wraps the counter
      fetch_decode(3'd1, 4'd13);
      chk("br_state", 16'(state), 16'd9);
      chk("br_aluop", 16'(ALUOp), 16'd9);
      chk("br_srcb", 16'(ALUSrcB), 16'd2);
      chk("br_branch", 16'(Branch), 16'd1);
      chk("br_type", 16'(BranchType), 16'd1);
      tick();
      stall = 1'b1;
      #1;
      chk("br2_stall1_state", 16'(state), 16'd10);
      chk("br2_stall1_pcw", 16'(PCWrite), 16'd0);
      chk("br2_stall1_ret", 16'(retired), 16'd0);
      chk("br2_stall1_pcsrc", 16'(PCSrc), 16'd1);
      tick();
      chk("br2_stall2_state", 16'(state), 16'd10);
      chk("br2_stall2_pcw", 16'(PCWrite), 16'd0);
      chk("br2_stall2_count", 16'(retired_count), 16'd7);
      tick();
      stall = 1'b0;
      #1;
      chk("br2_go_state", 16'(state), 16'd10);
      chk("br2_go_pcw", 16'(PCWrite), 16'd1);
      chk("br2_go_pcsrc", 16'(PCSrc), 16'd1);
      chk("br2_go_ret", 16'(retired), 16'd1);
      tick();
      chk("br_done_state", 16'(state), 16'd0);
      chk("br_wrap_count", 16'(retired_count), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multi-cycle control FSM for the 16-bit datapath; the next generation of the core controller. It decodes opcode/func and sequences the datapath through fetch, decode, execute, memory and writeback. Beyond the basic sequencing it adds:
- memory ready handshake with a timeout;
- a pipeline-style stall input;
- illegal-instruction and timeout fault trapping;
- a retired-instruction counter.

## Interface
Parameters:
- OPC_W, 3, opcode width (encodings 0–4 legal, all others illegal)
- FUNC_W, 4, func width (must be ≥4; upper bits above [3:0] must be zero or the instruction is illegal)
- TMO_W, 4, memory-wait counter width; timeout after 2^TMO_W−1 wait cycles
- CNT_W, 16, retired-instruction counter width

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous active-low reset
- opcode  in  OPC_W  instruction opcode from IR
- func  in  FUNC_W  instruction func from IR
- mem_ready  in  1  memory completes the current MemR/MemW access this cycle
- stall  in  1  freeze FSM and suppress all enables
- clear_fault  in  1  leave FAULT
- Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc, PCWrite, RegWrite  out  1 each  datapath controls
- ALUSrcA, ALUSrcB, BranchType  out  2 each  mux selects / branch condition (func[1:0])
- ALUOp  out  4  ALU operation
- state  out  4  current state code
- fault  out  1  FSM is in FAULT
- fault_cause  out  2  0 none, 1 illegal opcode/func, 2 memory timeout; sticky
- retired  out  1  one-cycle pulse when an instruction completes
- retired_count  out  CNT_W  wrapping count of retired pulses

## Operation
State codes: FETCH 0, DECODE 1, RTYPE 2, RITYPE 3, RTYPEEND 4, LW1 5, LW2 6, SW 7, JALR 8, BRANCH 9, BRANCH2 10, JAL 11, LUI 12, FAULT 15.

Default outputs in every state are all zero, except ALUOp, which defaults to 4'b1111.

Per-state outputs:
- FETCH: MemR=1, ALUOp=0, ALUSrcB=1. IRWrite and PCWrite are 1 only when mem_ready=1.
- DECODE: all defaults.
- RTYPE: ALUOp=func-map, ALUSrcA=2, ALUSrcB=0.
- RITYPE: as RTYPE but ALUSrcB=2.
- RTYPEEND: RegWrite=1.
- LW1: IoD=1, MemR=1.
- LW2: RegWrite=1, Mem2Reg=1.
- SW: IoD=1, MemW=1.
- JALR and JAL: ALUSrcA=3, ALUSrcB=1, ALUOp=7, PCWrite=1. JALR also sets RegWrite=1.
- BRANCH: ALUOp=9, ALUSrcB=2, Branch=1, BranchType=func[1:0].
- BRANCH2: ALUOp=1, ALUSrcA=2, Branch=1, BranchType=func[1:0], PCSrc=1, PCWrite=1.
- LUI: ALUSrcB=3, ALUOp=0, RegWrite=1.
- FAULT: defaults; fault=1.

Func-map for ALUOp:
- func 0–8 pass through unchanged.
- func 9 and 10 (lw/sw) map to 9.
- In RITYPE reached via opcode 2, func 11–15 are illegal.

DECODE transitions:
- opcode 0 → RTYPE; func ≥9 → FAULT (illegal).
- opcode 1: func 11 → JALR; func 12–15 → BRANCH; otherwise → RITYPE.
- opcode 2: func ≤10 → RITYPE; otherwise → FAULT (illegal).
- opcode 3 → LUI.
- opcode 4 → JAL.
- any other opcode → FAULT, cause 1.

Other transitions:
- RTYPE → RTYPEEND.
- RITYPE: func 9 → LW1; func 10 → SW; otherwise → RTYPEEND.
- LW1 → LW2.
- BRANCH → BRANCH2.
- RTYPEEND, LW2, JAL, JALR, BRANCH2, LUI → FETCH.
- FETCH → DECODE, LW1 → LW2, SW → FETCH: each only on mem_ready=1; otherwise hold.

Memory wait:
- Wait states are FETCH, LW1 and SW. The wait counter increments each held cycle there and clears on state change.
- When the counter reaches 2^TMO_W−1 with mem_ready=0, next state is FAULT with cause 2.

Retire:
- retired=1 in the last cycle of RTYPEEND, LW2, JAL, JALR, BRANCH2, LUI.
- retired=1 in SW in the cycle mem_ready=1.
- retired_count increments on each pulse and wraps to 0 at the maximum.

FAULT:
- FSM holds in FAULT until clear_fault=1, then goes to FETCH on the next edge.
- fault_cause keeps its value until clear_fault, then clears to 0.

Stall:
- With stall=1 the state, wait counter and retired_count hold.
- RegWrite, PCWrite, IRWrite, MemW, MemR and retired are forced to 0; other outputs follow the held state.
- stall is ignored in FAULT; clear_fault still works there.

## Timing
- Reset low: immediately state=FETCH, counters=0, fault=0, fault_cause=0, retired=0. Outputs take FETCH values: MemR=1, ALUSrcB=1, ALUOp=0, all other outputs 0, IRWrite/PCWrite=mem_ready. Reset asserted mid-instruction aborts it.
- State, counters and fault_cause update on the rising CLK edge. Outputs are combinational from state plus the mem_ready/stall gating.
- Cycle counts with mem_ready tied high and no stall:
  - R-type, RI, SW, branch: 4 cycles.
  - LW: 5 cycles.
  - JAL, JALR, LUI: 3 cycles.
  - Each memory wait cycle adds 1.

## Test plan
- Reset low mid-LW2 → state=0, RegWrite=0, retired_count=0 immediately; FETCH resumes after release.
- opcode 0, func 1, mem_ready=1 → states 0,1,2,4; ALUOp=1 in RTYPE; RegWrite=1 and retired=1 in the 4th cycle; retired_count=1.
- LW (opcode 2, func 9) with mem_ready low for 3 cycles in LW1 → LW1 held 4 cycles, MemR=1 throughout, then LW2 with RegWrite=1 and Mem2Reg=1.
- opcode 6 → FAULT after DECODE with fault_cause=1; asserting clear_fault → FETCH next cycle, fault_cause=0.
- TMO_W=2, mem_ready=0 in FETCH → FAULT after 3 held cycles, cause 2, IRWrite never 1.
- stall=1 for 2 cycles in BRANCH2 → state stays 10 with PCWrite=0; on release PCWrite=1 and PCSrc=1 for one cycle; retired_count wraps from all-ones to 0.
